// File: rtl/race_pkg.sv
// race_pkg: screen codes, countdown start value and position-width helper shared by the race blocks.
package race_pkg;
    typedef enum logic [1:0] {
        SCR_MENU      = 2'b00,
        SCR_RACE      = 2'b01,
        SCR_FINISH    = 2'b10,
        SCR_COUNTDOWN = 2'b11
    } screen_t;

    localparam logic [1:0] COUNTDOWN_START = 2'd3;

    function automatic int pos_w(input int max_pos);
        return (max_pos > 1) ? $clog2(max_pos) : 1;
    endfunction
endpackage

// File: rtl/race_timer.sv
// race_timer: loadable down-counter that parks at zero; shared by countdown, idle and finish phases.
module race_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/race_controller.sv
// race_controller: menu -> countdown -> race -> finish sequencer with winner/tie detection
// and a one-cycle players_reset pulse to re-arm the player buttons.
module race_controller
    import race_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int MAX_POS       = 16,
    parameter int STEP_CYCLES   = 12_000_000,
    parameter int FINISH_CYCLES = 36_000_000,
    parameter int IDLE_CYCLES   = 360_000_000,
    localparam int PW = pos_w(MAX_POS),
    localparam int WW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_PLAYERS-1:0]    ready_vec,
    input  logic [NUM_PLAYERS*PW-1:0] pos_flat,
    input  logic [NUM_PLAYERS-1:0]    activity_vec,
    output logic [1:0]                current_screen,
    output logic [1:0]                countdown,
    output logic [WW-1:0]             winner,
    output logic                      winner_valid,
    output logic                      tie,
    output logic                      players_reset
);
    localparam int TMAX = (STEP_CYCLES > FINISH_CYCLES)
        ? ((STEP_CYCLES > IDLE_CYCLES) ? STEP_CYCLES : IDLE_CYCLES)
        : ((FINISH_CYCLES > IDLE_CYCLES) ? FINISH_CYCLES : IDLE_CYCLES);
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] STEP_LD   = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] FINISH_LD = TW'(FINISH_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LD   = (IDLE_CYCLES == 0) ? '0 : TW'(IDLE_CYCLES - 1);
    localparam logic [PW-1:0] FIN_POS   = PW'(MAX_POS - 1);

    screen_t              screen_q, screen_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [WW-1:0]        win_q, win_d, first_idx;
    logic                 tie_q, tie_d, wv_q, wv_d, prst_q, prst_d;
    logic [NUM_PLAYERS-1:0] finish_vec;
    logic                 multi, t_load, t_en, t_zero;
    logic [TW-1:0]        t_val;

    race_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .zero     (t_zero)
    );

    // Scanning downwards leaves the lowest finishing index in first_idx.
    always_comb begin
        finish_vec = '0;
        first_idx  = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (pos_flat[i*PW +: PW] == FIN_POS) begin
                finish_vec[i] = 1'b1;
                first_idx     = WW'(i);
            end
        end
    end

    assign multi = |(finish_vec & (finish_vec - NUM_PLAYERS'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            screen_q <= SCR_MENU;
            cnt_q    <= '0;
            win_q    <= '0;
            tie_q    <= 1'b0;
            wv_q     <= 1'b0;
            prst_q   <= 1'b1;
        end else begin
            screen_q <= screen_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            tie_q    <= tie_d;
            wv_q     <= wv_d;
            prst_q   <= prst_d;
        end
    end

    always_comb begin
        screen_d = screen_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        tie_d    = tie_q;
        wv_d     = wv_q;
        prst_d   = 1'b0;
        t_load   = 1'b0;
        t_val    = STEP_LD;
        t_en     = screen_q != SCR_MENU;
        case (screen_q)
            SCR_MENU: begin
                // Ready bits are stale while the buttons are still being reset.
                if (&ready_vec && !prst_q) begin
                    screen_d = SCR_COUNTDOWN;
                    cnt_d    = COUNTDOWN_START;
                    t_load   = 1'b1;
                end
            end
            SCR_COUNTDOWN: begin
                if (t_zero) begin
                    t_load = 1'b1;
                    if (cnt_q > 2'd1) begin
                        cnt_d = cnt_q - 2'd1;
                    end else begin
                        screen_d = SCR_RACE;
                        cnt_d    = '0;
                        t_val    = IDLE_LD;
                    end
                end
            end
            SCR_RACE: begin
                if (|finish_vec) begin
                    screen_d = SCR_FINISH;
                    win_d    = first_idx;
                    tie_d    = multi;
                    wv_d     = 1'b1;
                    t_load   = 1'b1;
                    t_val    = FINISH_LD;
                end else if (|activity_vec) begin
                    t_load = 1'b1;
                    t_val  = IDLE_LD;
                end else if (t_zero && IDLE_CYCLES != 0) begin
                    screen_d = SCR_MENU;
                    prst_d   = 1'b1;
                end
            end
            SCR_FINISH: begin
                if (t_zero) begin
                    screen_d = SCR_MENU;
                    prst_d   = 1'b1;
                    wv_d     = 1'b0;
                    tie_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        current_screen = screen_q;
        countdown      = cnt_q;
        winner         = win_q;
        winner_valid   = wv_q;
        tie            = tie_q;
        players_reset  = prst_q;
    end
endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: scoreboard bench; stimulus queues expected output snapshots with the
// cycle they must appear, a monitor pops one on every output change and compares.
module tb_race_controller;
    import race_pkg::*;

    localparam int NP = 2, MP = 16, STEP = 4, FIN = 8, IDLE = 20;

    logic       clk = 1'b0, reset_n = 1'b1;
    logic [1:0] ready_vec = '0, activity_vec = '0;
    logic [7:0] pos_flat = '0;
    logic [1:0] current_screen, countdown;
    logic       winner, winner_valid, tie, players_reset;

    typedef struct packed {
        logic [1:0] scr;
        logic [1:0] cd;
        logic       w;
        logic       wv;
        logic       tie;
        logic       prst;
    } snap_t;

    typedef struct {
        string name;
        int    t;
        snap_t s;
    } exp_t;

    exp_t  expq[$];
    exp_t  e;
    snap_t cur_s, prev_s;
    int    cyc = 0, checks = 0, errors = 0;
    bit    mon_on = 1'b0;

    race_controller #(
        .NUM_PLAYERS   (NP),
        .MAX_POS       (MP),
        .STEP_CYCLES   (STEP),
        .FINISH_CYCLES (FIN),
        .IDLE_CYCLES   (IDLE)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ready_vec      (ready_vec),
        .pos_flat       (pos_flat),
        .activity_vec   (activity_vec),
        .current_screen (current_screen),
        .countdown      (countdown),
        .winner         (winner),
        .winner_valid   (winner_valid),
        .tie            (tie),
        .players_reset  (players_reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cur_s = {current_screen, countdown, winner, winner_valid, tie, players_reset};
        if (mon_on && cur_s != prev_s) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur_s, cyc);
            end else begin
                e = expq.pop_front();
                if (e.s != cur_s || e.t != cyc)begin
                    errors++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             e.name, cur_s, cyc, e.s, e.t);
                end
            end
        end
        prev_s = cur_s;
    end

    function automatic snap_t mk(input logic [1:0] scr, input logic [1:0] cd,
                                 input logic w, input logic wv, input logic t, input logic p);
        return {scr, cd, w, wv, t, p};
    endfunction

    task automatic expect_at(input string name, input int t, input snap_t s);
        exp_t x;
        x.name = name;
        x.t    = t;
        x.s    = s;
        expq.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Call at a negedge with players_reset low; returns the cycle of RACE entry.
    task automatic start_race(input logic w, output int r);
        int c;
        c = cyc;
        ready_vec = 2'b11;
        expect_at("cd3",        c + 1,            mk(SCR_COUNTDOWN, 2'd3, w, 1'b0, 1'b0, 1'b0));
        expect_at("cd2",        c + 1 + STEP,     mk(SCR_COUNTDOWN, 2'd2, w, 1'b0, 1'b0, 1'b0));
        expect_at("cd1",        c + 1 + 2 * STEP, mk(SCR_COUNTDOWN, 2'd1, w, 1'b0, 1'b0, 1'b0));
        expect_at("race_entry", c + 1 + 3 * STEP, mk(SCR_RACE,      2'd0, w, 1'b0, 1'b0, 1'b0));
        r = c + 1 + 3 * STEP;
        wait_until(r);
    endtask

    initial begin
        int r;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_screen", current_screen, SCR_MENU);
        check("rst_countdown", countdown, 0);
        check("rst_winner", winner, 0);
        check("rst_winner_valid", winner_valid, 0);
        check("rst_tie", tie, 0);
        check("rst_players_reset", players_reset, 1);
        mon_on = 1'b1;
        expect_at("prst_release", cyc + 1, mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b1;

        ready_vec = 2'b01;
        repeat (50) @(negedge clk);
        check("menu_hold", current_screen, SCR_MENU);

        start_race(1'b0, r);
        pos_flat = {4'd15, 4'd9};
        expect_at("finish_p1",   r + 1,       mk(SCR_FINISH, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        expect_at("finish_exit", r + 1 + FIN, mk(SCR_MENU,   2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        expect_at("menu_stays",  r + 2 + FIN, mk(SCR_MENU,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_until(r + 1);
        pos_flat = '0;
        wait_until(r + 2 + FIN);
        ready_vec = 2'b01;
        repeat (2) @(negedge clk);

        start_race(1'b1, r);
        pos_flat = {4'd15, 4'd15};
        ready_vec = 2'b01;
        expect_at("tie_entry", r + 1,       mk(SCR_FINISH, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        expect_at("tie_exit",  r + 1 + FIN, mk(SCR_MENU,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        expect_at("tie_drop",  r + 2 + FIN, mk(SCR_MENU,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_until(r + 1);
        pos_flat = '0;
        wait_until(r + 4 + FIN);

        start_race(1'b0, r);
        ready_vec = 2'b01;
        expect_at("idle_abort", r + IDLE,     mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        expect_at("idle_drop",  r + IDLE + 1, mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_until(r + IDLE + 3);

        start_race(1'b0, r);
        ready_vec = 2'b01;
        expect_at("act_abort", r + 2 * IDLE,     mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        expect_at("act_drop",  r + 2 * IDLE + 1, mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_until(r + IDLE - 1);
        activity_vec = 2'b10;
        wait_until(r + IDLE);
        activity_vec = 2'b00;
        wait_until(r + 2 * IDLE + 3);

        start_race(1'b0, r);
        ready_vec = 2'b01;
        expect_at("fin_over_idle", r + IDLE,           mk(SCR_FINISH, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        expect_at("fin_idle_exit", r + IDLE + FIN,     mk(SCR_MENU,   2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        expect_at("fin_idle_drop", r + IDLE + FIN + 1, mk(SCR_MENU,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_until(r + IDLE - 1);
        pos_flat = {4'd15, 4'd3};
        wait_until(r + IDLE);
        pos_flat = '0;
        wait_until(r + IDLE + FIN + 3);

        start_race(1'b1, r);
        ready_vec = 2'b01;
        wait_until(r + 3);
        expect_at("async_reset", r + 4, mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        #2 reset_n = 1'b0;
        #1;
        check("async_screen", current_screen, SCR_MENU);
        check("async_prst", players_reset, 1);
        wait_until(r + 6);
        expect_at("rst_release2", r + 7, mk(SCR_MENU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b1;
        wait_until(r + 10);

        check("scoreboard_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Top-level game sequencer for the LED race. Drives the shared current_screen bus seen by every player_button instance.
- Runs a menu → countdown → race → finish cycle and detects the winner from the packed player positions.
- Issues a synchronous players_reset pulse to re-arm all player_button instances after a finish or an idle timeout.

Parameters:
- NUM_PLAYERS, 2, number of player_button instances (≥2).
- MAX_POS, 16, track length; a player finishes at position MAX_POS-1.
- STEP_CYCLES, 12_000_000, clock cycles per countdown step (1 s at 12 MHz).
- FINISH_CYCLES, 36_000_000, cycles the finish screen is held.
- IDLE_CYCLES, 360_000_000, race abort timeout with no button activity; 0 disables it.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, reset, asynchronous, active-low.
- ready_vec, in, NUM_PLAYERS, per-player ready_to_play.
- pos_flat, in, NUM_PLAYERS*$clog2(MAX_POS), packed cur_pos; player i occupies bits [i*PW +: PW], where PW = $clog2(MAX_POS).
- activity_vec, in, NUM_PLAYERS, per-player raw button activity.
- current_screen, out, 2, screen code: 00 MENU, 11 COUNTDOWN, 01 RACE, 10 FINISH.
- countdown, out, 2, digit to display: 3/2/1 during COUNTDOWN, 0 otherwise.
- winner, out, WW = max(1,$clog2(NUM_PLAYERS)), index of the winning player.
- winner_valid, out, 1, high while in FINISH.
- tie, out, 1, more than one player finished on the same cycle.
- players_reset, out, 1, synchronous reset to all player_button instances.

Behaviour:
- Async reset values: current_screen=00, countdown=0, winner=0, winner_valid=0, tie=0, players_reset=1, timer=0. players_reset falls at the first clk edge after reset_n rises.
- All outputs are registered. Every transition below takes effect at the clk edge after its condition is sampled.
- MENU (00):
  - Condition: ready_vec all ones and players_reset==0.
  - Action: go to COUNTDOWN, countdown=3, timer=STEP_CYCLES-1.
  - The players_reset==0 guard covers the cycle where player_button ready bits are still stale.
- COUNTDOWN (11):
  - Timer decrements each cycle.
  - At timer==0 with countdown>1: countdown-=1 and the timer reloads.
  - At timer==0 with countdown==1: go to RACE, countdown=0, timer=IDLE_CYCLES-1.
  - Result: RACE starts exactly 3*STEP_CYCLES cycles after COUNTDOWN entry.
  - player_button ignores presses during this screen.
- RACE (01):
  - Finish detection: finish_vec[i] = (pos_i == MAX_POS-1).
  - If any finish_vec bit is set: go to FINISH, winner = lowest set index, tie = (popcount>1), winner_valid=1, timer=FINISH_CYCLES-1.
  - Idle timer: reloads on any activity_vec bit, otherwise decrements.
  - Idle expiry (timer==0, IDLE_CYCLES≠0): players_reset=1 for one cycle and go to MENU.
  - If finish and idle expiry occur on the same cycle, finish wins.
- FINISH (10):
  - Timer decrements.
  - At timer==0: go to MENU, players_reset=1 for exactly one cycle, winner_valid=0, tie=0.
  - winner keeps its value until the next FINISH entry.
- players_reset is high for one cycle only, except after async reset.
- Undefined screen codes cannot occur because all four codes are used.
- reset_n low at any time forces the reset values immediately. A mid-race reset therefore aborts to MENU; player_buttons are cleared via players_reset.
- Timer width: $clog2 of the maximum of STEP_CYCLES, FINISH_CYCLES and IDLE_CYCLES, at least 1 bit. No wrap: a timer at 0 reloads or the state leaves.

Decomposition:
- Package race_pkg holds:
  - screen codes SCR_MENU=2'b00, SCR_RACE=2'b01, SCR_FINISH=2'b10, SCR_COUNTDOWN=2'b11;
  - the countdown start value 3;
  - a width function pos_w(MAX_POS).
- player_button compares against SCR_MENU/SCR_RACE from the same package.
- One natural sub-module: race_timer. It is a loadable down-counter with inputs load, load_val, en and output zero; it is shared by the countdown, idle and finish phases.

Test Plan (NUM_PLAYERS=2, MAX_POS=16, STEP=4, FINISH=8, IDLE=20):
- reset_n low mid-RACE -> screen=00 immediately; players_reset=1 until the first edge after release.
- ready_vec=2'b01 held 50 cycles -> screen stays 00. Then ready_vec=2'b11 -> screen=11 next edge, countdown sequence 3,2,1 with 4 cycles each, screen=01 exactly 12 cycles after COUNTDOWN entry.
- RACE, pos1 reaches 15 while pos0=9 -> next edge screen=10, winner=1, tie=0, winner_valid=1. After 8 cycles: screen=00, players_reset high for 1 cycle. ready_vec still 11 during that cycle -> stays in MENU.
- RACE, pos0 and pos1 reach 15 on the same cycle -> winner=0, tie=1.
- RACE, no activity for 20 cycles -> players_reset pulse, screen=00, winner_valid=0. A pulse on activity_vec at cycle 19 delays the abort by 20 cycles.
- Finish and idle expiry on the same cycle -> FINISH entered, no players_reset pulse.
